// File: rtl/time_cnt_prog.sv
// time_cnt_prog
//   Programmable-limit timer counter. It counts clock cycles from 0 up to a
//   limit that is captured at restart. It runs either periodically (wrap to 0)
//   or as a one-shot (stop in DONE). A small IDLE/RUN/PAUSE/DONE FSM controls
//   it, and it emits a one-cycle terminal-count pulse plus a saturating tally
//   of terminal counts.
//
// Optional feature macro: TIME_CNT_DOWN_EN
//   When defined, the count_down input is added. It is captured at restart
//   into the direction flag. Down-counting loads limit_q, reaches terminal
//   at 0, reloads limit_q when periodic and holds 0 when one-shot.
//
// Parameters
//   WIDTH          counter / limit width
//   WRAP_W         wrap_count tally width (saturating)
//   DEFAULT_LIMIT  limit_q value after reset
//
// Ports
//   clock         in   single clock, posedge
//   reset_start   in   synchronous active-high reset
//   enable        in   count qualifier while running
//   start         in   restart from IDLE/DONE, resume from PAUSE
//   stop          in   RUN -> PAUSE
//   oneshot       in   mode captured on restart (1 = one-shot)
//   limit         in   terminal value captured on restart
//   count_down    in   (TIME_CNT_DOWN_EN only) direction captured on restart
//   time_counter  out  current count
//   tc_pulse      out  one-cycle terminal-count pulse
//   wrap_count    out  terminal counts since restart, saturating
//   running       out  state == RUN
//   done          out  state == DONE
module time_cnt_prog #(
  parameter int                WIDTH         = 8,
  parameter int                WRAP_W        = 4,
  parameter logic [WIDTH-1:0]  DEFAULT_LIMIT = {WIDTH{1'b1}}
) (
  input  logic              clock,
  input  logic              reset_start,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  input  logic [WIDTH-1:0]  limit,
`ifdef TIME_CNT_DOWN_EN
  input  logic              count_down,
`endif
  output logic [WIDTH-1:0]  time_counter,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              running,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_ZERO = {WRAP_W{1'b0}};
  localparam logic [WRAP_W-1:0] WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WIDTH-1:0]  cnt_r;
  logic [WIDTH-1:0]  cnt_nxt_s;
  logic [WIDTH-1:0]  lim_r;
  logic [WIDTH-1:0]  lim_nxt_s;
  logic              mode_r;
  logic              mode_nxt_s;
  logic              dir_r;
  logic              dir_nxt_s;
  logic [WRAP_W-1:0] wrap_r;
  logic [WRAP_W-1:0] wrap_nxt_s;
  logic              tc_r;
  logic              tc_nxt_s;
  logic              running_r;
  logic              done_r;
  logic              count_down_s;
  logic              terminal_s;
  logic              start_ok_s;

`ifdef TIME_CNT_DOWN_EN
  assign count_down_s = count_down;
`else
  assign count_down_s = 1'b0;
`endif

  // A stop in the same cycle always blocks start (stop has priority).
  assign start_ok_s = start & ~stop;
  // Terminal value depends on direction: limit_q when up, 0 when down.
  assign terminal_s = dir_r ? (cnt_r == CNT_ZERO) : (cnt_r == lim_r);

  // State register.
  always_ff @(posedge clock) begin
    if (reset_start) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath next-value logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    lim_nxt_s   = lim_r;
    mode_nxt_s  = mode_r;
    dir_nxt_s   = dir_r;
    wrap_nxt_s  = wrap_r;
    tc_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_RUN;
          lim_nxt_s   = limit;
          mode_nxt_s  = oneshot;
          dir_nxt_s   = count_down_s;
          cnt_nxt_s   = count_down_s ? limit : CNT_ZERO;
          wrap_nxt_s  = WRAP_ZERO;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt_s = ST_PAUSE;
        end else if (enable) begin
          if (terminal_s) begin
            tc_nxt_s   = 1'b1;
            wrap_nxt_s = (wrap_r == WRAP_MAX) ? WRAP_MAX : (wrap_r + WRAP_ONE);
            if (mode_r) begin
              // One-shot: counter already sits on its terminal value; hold it.
              state_nxt_s = ST_DONE;
            end else begin
              cnt_nxt_s = dir_r ? lim_r : CNT_ZERO;
            end
          end else begin
            cnt_nxt_s = dir_r ? (cnt_r - CNT_ONE) : (cnt_r + CNT_ONE);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_PAUSE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset_start) begin
      cnt_r     <= CNT_ZERO;
      lim_r     <= DEFAULT_LIMIT;
      mode_r    <= 1'b0;
      dir_r     <= 1'b0;
      wrap_r    <= WRAP_ZERO;
      tc_r      <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      lim_r     <= lim_nxt_s;
      mode_r    <= mode_nxt_s;
      dir_r     <= dir_nxt_s;
      wrap_r    <= wrap_nxt_s;
      tc_r      <= tc_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  assign time_counter = cnt_r;
  assign tc_pulse     = tc_r;
  assign wrap_count   = wrap_r;
  assign running      = running_r;
  assign done         = done_r;

endmodule

// File: tb/tb_time_cnt_prog.sv
module tb_time_cnt_prog;

  logic       clock;
  logic       reset_start;
  logic       enable;
  logic       start;
  logic       stop;
  logic       oneshot;
  logic [7:0] limit;
  logic       count_down;
  logic [7:0] time_counter;
  logic       tc_pulse;
  logic [3:0] wrap_count;
  logic       running;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference model state (behavioural, plain integers and a state name)
  string m_st;
  int    m_cnt;
  int    m_lim;
  int    m_wrap;
  bit    m_tc;
  bit    m_one;
  bit    m_down;

  time_cnt_prog dut (
    .clock        (clock),
    .reset_start  (reset_start),
    .enable       (enable),
    .start        (start),
    .stop         (stop),
    .oneshot      (oneshot),
    .limit        (limit),
`ifdef TIME_CNT_DOWN_EN
    .count_down   (count_down),
`endif
    .time_counter (time_counter),
    .tc_pulse     (tc_pulse),
    .wrap_count   (wrap_count),
    .running      (running),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model one clock edge from the inputs currently applied.
  task automatic model_step();
    bit term;
    if (reset_start) begin
      m_st = "IDLE"; m_cnt = 0; m_lim = 255; m_wrap = 0; m_tc = 0; m_one = 0; m_down = 0;
    end else begin
      m_tc = 0;
      if (m_st == "RUN" && stop) begin
        m_st = "PAUSE";
      end else if ((m_st == "IDLE" || m_st == "DONE") && start && !stop) begin
        m_st   = "RUN";
        m_lim  = int'(limit);
        m_one  = oneshot;
`ifdef TIME_CNT_DOWN_EN
        m_down = count_down;
`else
        m_down = 0;
`endif
        m_cnt  = m_down ? m_lim : 0;
        m_wrap = 0;
      end else if (m_st == "PAUSE" && start && !stop) begin
        m_st = "RUN";
      end else if (m_st == "RUN" && enable) begin
        term = m_down ? (m_cnt == 0) : (m_cnt == m_lim);
        if (term) begin
          m_tc   = 1;
          m_wrap = (m_wrap + 1 > 15) ? 15 : m_wrap + 1;
          if (m_one) m_st = "DONE";
        end
        if (m_one) begin
          m_cnt = m_down ? ((m_cnt > 0) ? m_cnt - 1 : 0)
                         : ((m_cnt < m_lim) ? m_cnt + 1 : m_lim);
        end else begin
          m_cnt = m_down ? (m_cnt + m_lim) % (m_lim + 1)
                         : (m_cnt + 1) % (m_lim + 1);
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    chk({tag, ".counter"}, 32'(time_counter), 32'(m_cnt));
    chk({tag, ".tc"},      32'(tc_pulse),     32'(m_tc));
    chk({tag, ".wrap"},    32'(wrap_count),   32'(m_wrap));
    chk({tag, ".running"}, 32'(running),      32'(m_st == "RUN"));
    chk({tag, ".done"},    32'(done),         32'(m_st == "DONE"));
  endtask

  task automatic drv(input logic rs, input logic en, input logic st, input logic sp,
                     input logic os, input int lim);
    reset_start = rs; enable = en; start = st; stop = sp; oneshot = os; limit = 8'(lim);
  endtask

  initial begin
    count_down = 1'b0;
    m_st = "IDLE"; m_cnt = 0; m_lim = 255; m_wrap = 0; m_tc = 0; m_one = 0; m_down = 0;
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick("reset"); tick("reset");

    // 1: periodic, limit 3
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3); tick("per_start");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    for (int i = 0; i < 12; i++) tick("per_run");
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7); tick("per_start_ignored");

    // 2: one-shot, limit 5, then restart
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0); tick("os_stop");
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0); tick("os_reset");
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5); tick("os_start");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    for (int i = 0; i < 9; i++) tick("os_run");
    chk("os_done_flag", 32'(done), 32'd1);
    chk("os_hold", 32'(time_counter), 32'd5);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5); tick("os_restart");
    chk("os_restart_wrap", 32'(wrap_count), 32'd0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    tick("os_restart_run");

    // 3: pause at 2 with limit 9, limit change in pause has no effect
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0); tick("pause_reset");
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9); tick("pause_start");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9); tick("pause_run"); tick("pause_run");
    drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9); tick("pause_stop");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    for (int i = 0; i < 10; i++) tick("pause_hold");
    chk("pause_held2", 32'(time_counter), 32'd2);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4); tick("pause_resume");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    for (int i = 0; i < 12; i++) tick("pause_after");

    // 4: limit 0 periodic, saturation and enable gating
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0); tick("lim0_reset");
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0); tick("lim0_start");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 18; i++) tick("lim0_run");
    chk("lim0_sat", 32'(wrap_count), 32'd15);
    for (int i = 0; i < 8; i++) begin
      enable = i[0];
      tick("lim0_gate");
    end

    // 5: start+stop in IDLE, reset at count 7
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0); tick("ss_reset");
    drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20); tick("ss_idle");
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20); tick("r7_start");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20);
    for (int i = 0; i < 7; i++) tick("r7_run");
    chk("r7_at7", 32'(time_counter), 32'd7);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20); tick("r7_reset");

`ifdef TIME_CNT_DOWN_EN
    // 6: down count periodic, then one-shot
    count_down = 1'b1;
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3); tick("dn_start");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    for (int i = 0; i < 9; i++) tick("dn_run");
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3); tick("dn_reset");
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3); tick("dn_os_start");
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    for (int i = 0; i < 7; i++) tick("dn_os_run");
    count_down = 1'b0;
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset_start = ($urandom_range(0, 149) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 19) == 0);
      oneshot     = 1'($urandom_range(0, 1));
      limit       = 8'($urandom_range(0, 10));
`ifdef TIME_CNT_DOWN_EN
      count_down  = 1'($urandom_range(0, 1));
`endif
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
